// File: rtl/egd_bitstream_sequencer.sv
// egd_bitstream_sequencer
// Bridges firmware-driven LA control pins to the H.264 decoder core.
// Bitstream words arrive one per toggle of la_ctrl_i[0], are buffered in a
// small FIFO, and are streamed to the decoder over valid/ready while a decode
// run (la_ctrl_i[1] held high) is active. A run-control FSM issues start/abort
// pulses and tracks completed frames and sticky error/overflow flags.
module egd_bitstream_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] la_word_i,
  input  logic [1:0]  la_ctrl_i,
  output logic [15:0] bs_data_o,
  output logic        bs_valid_o,
  input  logic        bs_ready_i,
  output logic        dec_start_o,
  output logic        dec_abort_o,
  input  logic        dec_done_i,
  input  logic        dec_err_i,
  output logic [7:0]  frame_cnt_o,
  output logic [2:0]  state_o,
  output logic [3:0]  fifo_lvl_o,
  output logic [1:0]  flags_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_STREAM = 3'd2,
    S_DONE   = 3'd3,
    S_ABORT  = 3'd4
  } state_t;

  localparam logic [3:0] LVL_FULL = 4'(DEPTH);

  state_t        r_state;
  logic          r_tog_q;
  logic          r_run_q;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [3:0]    r_lvl;
  logic          r_start;
  logic          r_abort;
  logic [7:0]    r_frame;
  logic [1:0]    r_flags;

  logic w_push_req;
  logic w_push;
  logic w_pop;
  logic w_ovf;
  logic w_empty;
  logic w_full;
  logic w_rise;
  logic w_fall;
  logic w_accepting;

  // Either edge of the write toggle marks a new word from firmware.
  assign w_push_req  = la_ctrl_i[0] ^ r_tog_q;
  assign w_rise      = la_ctrl_i[1] & ~r_run_q;
  assign w_fall      = ~la_ctrl_i[1] & r_run_q;
  assign w_empty     = (r_lvl == 4'd0);
  assign w_full      = (r_lvl == LVL_FULL);
  // The ABORT cycle flushes the FIFO, so words written then are silently lost.
  assign w_accepting = (r_state != S_ABORT);
  assign w_pop       = bs_valid_o & bs_ready_i;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign w_push      = w_push_req & w_accepting & (~w_full | w_pop);
  assign w_ovf       = w_push_req & w_accepting & w_full & ~w_pop;

  assign bs_valid_o  = (r_state == S_STREAM) & ~w_empty;
  assign bs_data_o   = r_mem[r_rptr];
  assign fifo_lvl_o  = r_lvl;
  assign state_o     = r_state;
  assign dec_start_o = r_start;
  assign dec_abort_o = r_abort;
  assign frame_cnt_o = r_frame;
  assign flags_o     = r_flags;

  // Capture toggle history and maintain FIFO storage, pointers and level.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_tog_q <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_lvl   <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 16'h0000;
      end
    end else begin
      r_tog_q <= la_ctrl_i[0];
      if (r_state == S_ABORT) begin
        r_rptr <= r_wptr;
        r_lvl  <= 4'd0;
      end else begin
        if (w_push) begin
          r_mem[r_wptr] <= la_word_i;
          r_wptr        <= r_wptr + AW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_lvl <= r_lvl + 4'd1;
          2'b01:   r_lvl <= r_lvl - 4'd1;
          default: r_lvl <= r_lvl;
        endcase
      end
    end
  end

  // Run-control FSM with registered pulses, frame counter and sticky flags.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_run_q <= 1'b0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_frame <= 8'd0;
      r_flags <= 2'b00;
    end else begin
      r_run_q <= la_ctrl_i[1];
      r_start <= 1'b0;
      r_abort <= 1'b0;
      if (w_ovf) begin
        r_flags[0] <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_START;
            r_start <= 1'b1;
            r_flags <= {1'b0, w_ovf};
          end
        end
        S_START: begin
          if (w_fall) begin
            r_state <= S_ABORT;
            r_abort <= 1'b1;
          end else begin
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_fall) begin
            r_state <= S_ABORT;
            r_abort <= 1'b1;
          end else if (dec_err_i) begin
            r_flags[1] <= 1'b1;
            if (dec_done_i) begin
              r_frame <= r_frame + 8'd1;
            end
            r_state <= S_DONE;
          end else if (dec_done_i) begin
            r_frame <= r_frame + 8'd1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!la_ctrl_i[1]) begin
            r_state <= S_IDLE;
          end
        end
        S_ABORT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_egd_bitstream_sequencer.sv
// Directed testbench for egd_bitstream_sequencer (DEPTH=8).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_egd_bitstream_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] word;
  logic [1:0]  ctrl;
  logic [15:0] bs_data;
  logic        bs_valid;
  logic        bs_ready;
  logic        dec_start;
  logic        dec_abort;
  logic        dec_done;
  logic        dec_err;
  logic [7:0]  frame_cnt;
  logic [2:0]  state;
  logic [3:0]  fifo_lvl;
  logic [1:0]  flags;

  int total;
  int bad;

  egd_bitstream_sequencer #(.DEPTH(8), .AW(3)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .la_word_i   (word),
    .la_ctrl_i   (ctrl),
    .bs_data_o   (bs_data),
    .bs_valid_o  (bs_valid),
    .bs_ready_i  (bs_ready),
    .dec_start_o (dec_start),
    .dec_abort_o (dec_abort),
    .dec_done_i  (dec_done),
    .dec_err_i   (dec_err),
    .frame_cnt_o (frame_cnt),
    .state_o     (state),
    .fifo_lvl_o  (fifo_lvl),
    .flags_o     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    word    = w;
    ctrl[0] = ~ctrl[0];
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; ctrl = 2'b00; word = 16'h0; bs_ready = 1'b0;
    dec_done = 1'b0; dec_err = 1'b0;
    step();
    step();
    total++;
    if ({bs_data, bs_valid, dec_start, dec_abort, frame_cnt, state, fifo_lvl, flags} !== 37'd0) begin
      bad++;
      $display("FAIL reset_outputs: got data=%h vld=%b st=%0d lvl=%0d flags=%b, want all zero",
               bs_data, bs_valid, state, fifo_lvl, flags);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_capture();
    push_word(16'h0001);
    push_word(16'h0002);
    push_word(16'h0003);
    total++;
    if (fifo_lvl !== 4'd3) begin bad++; $display("FAIL cap_lvl: got %0d want 3", fifo_lvl); end
    total++;
    if (state !== 3'd0 || bs_valid !== 1'b0) begin
      bad++; $display("FAIL cap_idle: got st=%0d vld=%b want st=0 vld=0", state, bs_valid);
    end
    total++;
    if (bs_data !== 16'h0001) begin bad++; $display("FAIL cap_head: got %h want 0001", bs_data); end
  endtask

  task automatic test_stream();
    bs_ready = 1'b1;
    ctrl[1]  = 1'b1;
    step();
    total++;
    if (state !== 3'd1 || dec_start !== 1'b1 || bs_valid !== 1'b0) begin
      bad++; $display("FAIL start_pulse: got st=%0d start=%b vld=%b want 1 1 0", state, dec_start, bs_valid);
    end
    step();
    total++;
    if (state !== 3'd2 || dec_start !== 1'b0) begin
      bad++; $display("FAIL start_once: got st=%0d start=%b want 2 0", state, dec_start);
    end
    for (int i = 1; i <= 3; i++) begin
      total++;
      if (bs_valid !== 1'b1 || bs_data !== 16'(i) || fifo_lvl !== 4'(4 - i)) begin
        bad++; $display("FAIL stream_word%0d: got vld=%b data=%h lvl=%0d want 1 %h %0d",
                        i, bs_valid, bs_data, fifo_lvl, 16'(i), 4 - i);
      end
      step();
    end
    total++;
    if (fifo_lvl !== 4'd0 || bs_valid !== 1'b0) begin
      bad++; $display("FAIL stream_empty: got lvl=%0d vld=%b want 0 0", fifo_lvl, bs_valid);
    end
  endtask

  task automatic test_done();
    dec_done = 1'b1;
    step();
    dec_done = 1'b0;
    total++;
    if (frame_cnt !== 8'd1 || state !== 3'd3) begin
      bad++; $display("FAIL done_count: got cnt=%0d st=%0d want 1 3", frame_cnt, state);
    end
    ctrl[1] = 1'b0;
    step();
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL done_idle: got st=%0d want 0", state); end
    dec_done = 1'b1;
    step();
    dec_done = 1'b0;
    total++;
    if (frame_cnt !== 8'd1 || state !== 3'd0) begin
      bad++; $display("FAIL done_ignored_idle: got cnt=%0d st=%0d want 1 0", frame_cnt, state);
    end
  endtask

  task automatic test_overflow();
    bs_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(16'h0010 + 16'(i));
    total++;
    if (fifo_lvl !== 4'd8 || flags !== 2'b00) begin
      bad++; $display("FAIL ovf_full: got lvl=%0d flags=%b want 8 00", fifo_lvl, flags);
    end
    push_word(16'h0018);
    total++;
    if (fifo_lvl !== 4'd8 || flags !== 2'b01) begin
      bad++; $display("FAIL ovf_flag: got lvl=%0d flags=%b want 8 01", fifo_lvl, flags);
    end
    ctrl[1] = 1'b1;
    step();
    total++;
    if (state !== 3'd1 || flags !== 2'b00) begin
      bad++; $display("FAIL ovf_clear: got st=%0d flags=%b want 1 00", state, flags);
    end
    step();
    bs_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bs_data !== 16'h0010 + 16'(i) || bs_valid !== 1'b1) begin
        bad++; $display("FAIL ovf_drain%0d: got data=%h vld=%b want %h 1", i, bs_data, bs_valid, 16'h0010 + 16'(i));
      end
      step();
    end
    total++;
    if (fifo_lvl !== 4'd0 || bs_valid !== 1'b0) begin
      bad++; $display("FAIL ovf_lost9: got lvl=%0d vld=%b want 0 0", fifo_lvl, bs_valid);
    end
    bs_ready = 1'b0;
    ctrl[1]  = 1'b0;
    step();
    step();
  endtask

  task automatic test_abort();
    for (int i = 1; i <= 4; i++) push_word(16'h0020 + 16'(i));
    ctrl[1] = 1'b1;
    step();
    step();
    total++;
    if (state !== 3'd2 || fifo_lvl !== 4'd4 || bs_valid !== 1'b1) begin
      bad++; $display("FAIL abort_pre: got st=%0d lvl=%0d vld=%b want 2 4 1", state, fifo_lvl, bs_valid);
    end
    ctrl[1] = 1'b0;
    step();
    total++;
    if (state !== 3'd4 || dec_abort !== 1'b1) begin
      bad++; $display("FAIL abort_pulse: got st=%0d abort=%b want 4 1", state, dec_abort);
    end
    step();
    total++;
    if (state !== 3'd0 || dec_abort !== 1'b0 || fifo_lvl !== 4'd0) begin
      bad++; $display("FAIL abort_flush: got st=%0d abort=%b lvl=%0d want 0 0 0", state, dec_abort, fifo_lvl);
    end
  endtask

  task automatic test_error();
    ctrl[1] = 1'b1;
    step();
    step();
    dec_err  = 1'b1;
    dec_done = 1'b1;
    step();
    dec_err  = 1'b0;
    dec_done = 1'b0;
    total++;
    if (flags !== 2'b10 || frame_cnt !== 8'd2 || state !== 3'd3) begin
      bad++; $display("FAIL err_done: got flags=%b cnt=%0d st=%0d want 10 2 3", flags, frame_cnt, state);
    end
    ctrl[1] = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) push_word(16'h0030 + 16'(i));
    ctrl[1] = 1'b1;
    step();
    step();
    total++;
    if (state !== 3'd2 || fifo_lvl !== 4'd8) begin
      bad++; $display("FAIL b2b_pre: got st=%0d lvl=%0d want 2 8", state, fifo_lvl);
    end
    bs_ready = 1'b1;
    push_word(16'h0038);
    bs_ready = 1'b0;
    total++;
    if (fifo_lvl !== 4'd8 || flags !== 2'b00 || bs_data !== 16'h0031) begin
      bad++; $display("FAIL b2b_full: got lvl=%0d flags=%b data=%h want 8 00 0031", fifo_lvl, flags, bs_data);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bs_data, bs_valid, dec_start, dec_abort, frame_cnt, state, fifo_lvl, flags} !== 37'd0) begin
      bad++; $display("FAIL async_reset: got data=%h vld=%b cnt=%0d st=%0d lvl=%0d flags=%b want all zero",
                      bs_data, bs_valid, frame_cnt, state, fifo_lvl, flags);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_capture();
    test_stream();
    test_done();
    test_overflow();
    test_abort();
    test_error();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
